// File: rtl/id_hazard_ctrl_if.sv
// Bundle between the fetch/pipeline side (master) and the decode-stage hazard controller (slave).
interface id_hazard_ctrl_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        flush;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [1:0]  sign_ext_sel;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic        id_is_load;
  logic        id_illegal;
  logic [1:0]  dbg_state;

  modport master (
    output if_valid, if_instr, flush,
    input  id_instr, id_valid, sign_ext_sel, pc_write, ifid_write,
           idex_bubble, id_is_load, id_illegal, dbg_state
  );

  modport slave (
    input  if_valid, if_instr, flush,
    output id_instr, id_valid, sign_ext_sel, pc_write, ifid_write,
           idex_bubble, id_is_load, id_illegal, dbg_state
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Decode-stage controller: IF/ID register, instruction classification and load-use stall/flush control.
// Optional HAZARD_STATS_EN adds saturating stall_count/flush_count outputs.
module id_hazard_ctrl #(
  parameter int unsigned XZR_IDX      = 31,
  parameter logic [1:0]  IMM_FALLBACK = 2'b00
) (
  input  logic              clk,
  input  logic              reset,
  id_hazard_ctrl_if.slave   bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       stall_count,
  output logic [15:0]       flush_count
`endif
);

  localparam logic [4:0]  XZR_R   = XZR_IDX[4:0];
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10
  } state_t;

  logic [31:0] id_instr_r;
  logic        id_valid_r;
  logic        ex_load_r;
  logic [4:0]  ex_rd_r;

  logic [1:0]  sel_s;
  logic        load_s;
  logic        legal_s;
  logic        src_a_en_s;
  logic        src_b_en_s;
  logic [4:0]  src_a_s;
  logic [4:0]  src_b_s;
  logic        stall_s;
  state_t      state_s;

  // Opcode decode: immediate format and which register fields are read in ID.
  always_comb begin
    sel_s      = IMM_FALLBACK;
    load_s     = 1'b0;
    legal_s    = 1'b0;
    src_a_en_s = 1'b0;
    src_b_en_s = 1'b0;
    src_a_s    = id_instr_r[9:5];
    src_b_s    = id_instr_r[20:16];
    if (id_instr_r[31:21] == OP_LDUR) begin
      sel_s      = 2'b01;
      load_s     = 1'b1;
      legal_s    = 1'b1;
      src_a_en_s = 1'b1;
    end else if (id_instr_r[31:21] == OP_STUR) begin
      sel_s      = 2'b01;
      legal_s    = 1'b1;
      src_a_en_s = 1'b1;
      src_b_en_s = 1'b1;
      src_b_s    = id_instr_r[4:0];
    end else if ((id_instr_r[31:21] == OP_ADD) || (id_instr_r[31:21] == OP_SUB) ||
                 (id_instr_r[31:21] == OP_AND) || (id_instr_r[31:21] == OP_ORR)) begin
      legal_s    = 1'b1;
      src_a_en_s = 1'b1;
      src_b_en_s = 1'b1;
    end else if ((id_instr_r[31:22] == OP_ADDI) || (id_instr_r[31:22] == OP_SUBI)) begin
      sel_s      = 2'b00;
      legal_s    = 1'b1;
      src_a_en_s = 1'b1;
    end else if (id_instr_r[31:26] == OP_B) begin
      sel_s      = 2'b10;
      legal_s    = 1'b1;
    end else if ((id_instr_r[31:24] == OP_CBZ) || (id_instr_r[31:24] == OP_CBNZ)) begin
      sel_s      = 2'b11;
      legal_s    = 1'b1;
      src_a_en_s = 1'b1;
      src_a_s    = id_instr_r[4:0];
    end else begin
      sel_s      = IMM_FALLBACK;
      legal_s    = 1'b0;
    end
  end

  // Load-use hazard: a load in EX writing a register that ID reads (X31 never counts).
  always_comb begin
    stall_s = id_valid_r & ex_load_r & (ex_rd_r != XZR_R) &
              ((src_a_en_s & (src_a_s == ex_rd_r)) | (src_b_en_s & (src_b_s == ex_rd_r)));
  end

  // Debug view of the decode slot, derived purely from registered state.
  always_comb begin
    state_s = ST_RUN;
    if (!id_valid_r) begin
      state_s = ST_EMPTY;
    end else if (stall_s) begin
      state_s = ST_STALL;
    end else begin
      state_s = ST_RUN;
    end
  end

  // IF/ID register and EX-stage load tracking; flush outranks stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_instr_r <= 32'd0;
      id_valid_r <= 1'b0;
      ex_load_r  <= 1'b0;
      ex_rd_r    <= 5'd0;
    end else begin
      ex_load_r <= id_valid_r & load_s & ~stall_s & ~bus.flush;
      ex_rd_r   <= id_instr_r[4:0];
      if (bus.flush) begin
        id_instr_r <= 32'd0;
        id_valid_r <= 1'b0;
      end else if (stall_s) begin
        id_instr_r <= id_instr_r;
        id_valid_r <= id_valid_r;
      end else begin
        id_instr_r <= bus.if_instr;
        id_valid_r <= bus.if_valid;
      end
    end
  end

  assign bus.id_instr     = id_instr_r;
  assign bus.id_valid     = id_valid_r;
  assign bus.sign_ext_sel = sel_s;
  assign bus.pc_write     = ~stall_s;
  assign bus.ifid_write   = ~stall_s;
  assign bus.idex_bubble  = stall_s | bus.flush | ~id_valid_r;
  assign bus.id_is_load   = id_valid_r & load_s;
  assign bus.id_illegal   = id_valid_r & ~legal_s;
  assign bus.dbg_state    = state_s;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;

  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 16'd0;
      flush_cnt_r <= 16'd0;
    end else begin
      if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (bus.flush && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_count = stall_cnt_r;
  assign flush_count = flush_cnt_r;
`endif

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
Decode-stage controller for the pipelined ARMv8 core. It owns the IF/ID pipeline register and classifies the instruction held in ID. It drives the immediate-format select into the sign-extension unit and detects load-use hazards against the instruction in EX. From those it generates the stall, bubble and flush controls that sequence IF/ID/EX.

Parameters:
XZR_IDX, 31, register index hardwired to zero; never creates a hazard
IMM_FALLBACK, 2'b00, select driven for non-immediate or unknown opcodes

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
if_valid  in  1  IF stage presents a fetched instruction
if_instr  in  32  fetched instruction word
flush  in  1  taken branch resolved downstream; squash ID and EX-bound slot
id_instr  out  32  registered IF/ID instruction
id_valid  out  1  id_instr is a live instruction
sign_ext_sel  out  2  immediate format to sign-extension unit: 00 I (ADDI/SUBI, [21:10]), 01 D (LDUR/STUR, [20:12]), 10 B ([25:0]), 11 CB (CBZ/CBNZ, [23:5])
pc_write  out  1  PC may advance
ifid_write  out  1  IF/ID register may load
idex_bubble  out  1  insert NOP into ID/EX this cycle
id_is_load  out  1  ID holds LDUR
id_illegal  out  1  id_valid and opcode unrecognised

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Decode of id_instr:
  - LDUR [31:21]=11111000010; STUR 11111000000.
  - R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - ADDI [31:22]=1001000100; SUBI 1101000100.
  - B [31:26]=000101.
  - CBZ [31:24]=10110100; CBNZ 10110101.
  - Anything else: illegal, sign_ext_sel=IMM_FALLBACK.
  - R-type drives IMM_FALLBACK.
- Source registers read in ID:
  - R-type: Rn [9:5] and Rm [20:16].
  - ADDI/SUBI/LDUR: Rn.
  - STUR: Rn and Rt [4:0].
  - CBZ/CBNZ: Rt.
  - B: none.
- Internal EX tracking registers ex_load and ex_rd[4:0]. At each edge:
  - ex_load <= id_valid & id_is_load & !stall & !flush.
  - ex_rd <= id_instr[4:0].
- stall (combinational) = id_valid & ex_load & (ex_rd != XZR_IDX) & (any ID source == ex_rd).
- Combinational outputs:
  - pc_write = ifid_write = !stall.
  - idex_bubble = stall | flush | !id_valid.
- IF/ID update, in priority order:
  - reset: id_instr=0, id_valid=0, ex_load=0, ex_rd=0.
  - flush: id_valid<=0, id_instr<=0.
  - stall: hold.
  - otherwise: id_instr<=if_instr, id_valid<=if_valid.
- State machine, derived from registers and exposed for debug only:
  - EMPTY (id_valid=0), RUN (id_valid & !stall), STALL (stall).
  - STALL always lasts exactly one cycle, because ex_load is cleared by the bubble.
  - STALL to RUN next cycle; flush from any state goes to EMPTY.
- Simultaneous flush and stall: flush wins. ID is cleared and the stall is dropped next cycle. pc_write remains !stall in the current cycle; the PC redirect comes from the branch unit.
- Reset-period outputs: id_valid=0, pc_write=1, ifid_write=1, idex_bubble=1, sign_ext_sel=IMM_FALLBACK (decode of 0 is illegal but masked by id_valid=0), id_is_load=0, id_illegal=0.
- if_valid=0 with no stall: ID becomes empty next cycle.
- Latency: if_instr to id_instr is 1 cycle; sign_ext_sel is combinational from id_instr.

Optional Feature:
HAZARD_STATS_EN:
- Defined: adds outputs stall_count[15:0] and flush_count[15:0].
  - stall_count increments on each cycle with stall=1.
  - flush_count increments on each cycle with flush=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset held 2 cycles, then release with if_valid=0 -> id_valid=0, pc_write=1, idex_bubble=1, sign_ext_sel=00.
- Feed 0xF8400022 (LDUR X2,[X1]) then 0x8B040043 (ADD X3,X2,X4).
  - Required: one cycle with stall=1, pc_write=0, ifid_write=0, idex_bubble=1, id_instr held at 0x8B040043.
  - Next cycle: pc_write=1.
- Feed LDUR 0xF840003F (Rt=X31) then ADD reading X31 -> no stall.
- Feed 0x91002BE1 (ADDI) -> sel=00; 0xF8400022 -> 01 with id_is_load=1; 0x14000004 (B) -> 10; 0xB4000045 (CBZ X5) -> 11.
- During the LDUR/ADD stall cycle, assert flush -> id_valid=0 next cycle, no second stall, stall_count=1 and flush_count=1 with HAZARD_STATS_EN.
- Feed 0xFFFFFFFF -> id_illegal=1, sign_ext_sel=00, pipeline keeps advancing.
